// File: rtl/power_spec_accumulator.sv
// Bin-by-bin accumulation of successive power spectra over a programmable shot
// count, using a read-modify-write pipeline around an internal dual-port RAM.
module power_spec_accumulator #(
   parameter int NFFT  = 1024,
   parameter int IN_W  = 32,
   parameter int CNT_W = 16,
   parameter int ACC_W = 48,
   parameter int IDX_W = $clog2(NFFT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acc_start,
   input  logic [CNT_W-1:0] acc_num,
   input  logic [IN_W-1:0]  power_spec,
   input  logic [IDX_W-1:0] data_index,
   input  logic             data_valid,
   output logic [ACC_W-1:0] acc_data,
   output logic [IDX_W-1:0] acc_index,
   output logic             acc_valid,
   output logic             acc_done,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_ACC      = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NFFT - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [CNT_W-1:0] num_r;
   logic [CNT_W-1:0] in_frame_r;

   logic             start_ok_s;
   logic             take_s;
   logic [CNT_W-1:0] num_eff_s;

   logic             s1_valid_r;
   logic [IDX_W-1:0] s1_index_r;
   logic [IN_W-1:0]  s1_power_r;
   logic             s1_first_r;
   logic             s1_last_r;
   logic             s1_end_r;

   logic             s2_valid_r;
   logic [IDX_W-1:0] s2_index_r;
   logic [IN_W-1:0]  s2_power_r;
   logic             s2_first_r;
   logic             s2_last_r;
   logic             s2_end_r;

   logic             wr_en_r;
   logic [IDX_W-1:0] wr_addr_r;
   logic [ACC_W-1:0] wr_data_r;

   logic [ACC_W-1:0] ram_r [NFFT];
   logic [ACC_W-1:0] ram_q_r;
   logic [ACC_W-1:0] pw_ext_s;
   logic [ACC_W-1:0] sum_s;

   // Start qualification and per-state sample acceptance
   always_comb begin
      start_ok_s = 1'b0;
      take_s     = 1'b0;
      num_eff_s  = acc_num;
      if (acc_num == CNT_ZERO) begin
         num_eff_s = CNT_ONE;
      end else begin
         num_eff_s = acc_num;
      end
      case (state_r)
         ST_IDLE:     start_ok_s = acc_start;
         ST_WAIT_SOF: take_s = data_valid && (data_index == IDX_ZERO);
         // once the last frame's final bin is in flight, further input is refused
         ST_ACC:      take_s = data_valid && (in_frame_r != num_r);
         default: begin
            start_ok_s = 1'b0;
            take_s     = 1'b0;
         end
      endcase
   end

   // Accumulation sum; the first frame of a run ignores whatever the RAM holds
   always_comb begin
      pw_ext_s = {{(ACC_W-IN_W){1'b0}}, s2_power_r};
      if (s2_first_r) begin
         sum_s = pw_ext_s;
      end else begin
         sum_s = ram_q_r + pw_ext_s;
      end
   end

   // Accumulator RAM: synchronous read of the stage-1 address, delayed write-back
   always_ff @(posedge clk) begin
      ram_q_r <= ram_r[s1_index_r];
      if (wr_en_r) begin
         ram_r[wr_addr_r] <= wr_data_r;
      end
   end

   // Control FSM, pipeline stages and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         num_r      <= CNT_ONE;
         in_frame_r <= CNT_ZERO;
         s1_valid_r <= 1'b0;
         s1_index_r <= IDX_ZERO;
         s1_power_r <= {IN_W{1'b0}};
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_end_r   <= 1'b0;
         s2_valid_r <= 1'b0;
         s2_index_r <= IDX_ZERO;
         s2_power_r <= {IN_W{1'b0}};
         s2_first_r <= 1'b0;
         s2_last_r  <= 1'b0;
         s2_end_r   <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= IDX_ZERO;
         wr_data_r  <= {ACC_W{1'b0}};
         acc_data   <= {ACC_W{1'b0}};
         acc_index  <= IDX_ZERO;
         acc_valid  <= 1'b0;
         acc_done   <= 1'b0;
         busy       <= 1'b0;
         frame_cnt  <= CNT_ZERO;
      end else begin
         s1_valid_r <= take_s;
         s1_index_r <= data_index;
         s1_power_r <= power_spec;
         s1_first_r <= (in_frame_r == CNT_ZERO);
         s1_last_r  <= (in_frame_r == (num_r - CNT_ONE));
         s1_end_r   <= (data_index == LAST_BIN);

         s2_valid_r <= s1_valid_r;
         s2_index_r <= s1_index_r;
         s2_power_r <= s1_power_r;
         s2_first_r <= s1_first_r;
         s2_last_r  <= s1_last_r;
         s2_end_r   <= s1_end_r;

         wr_en_r    <= s2_valid_r;
         wr_addr_r  <= s2_index_r;
         wr_data_r  <= sum_s;

         acc_valid  <= s2_valid_r && s2_last_r;
         acc_done   <= s2_valid_r && s2_last_r && s2_end_r;
         if (s2_valid_r && s2_last_r) begin
            acc_data  <= sum_s;
            acc_index <= s2_index_r;
         end

         // in_frame_r tracks frames at the input side so back-to-back frames tag correctly
         if (take_s && (data_index == LAST_BIN)) begin
            in_frame_r <= in_frame_r + CNT_ONE;
         end

         if (start_ok_s) begin
            frame_cnt <= CNT_ZERO;
         end else if (s2_valid_r && s2_end_r) begin
            frame_cnt <= frame_cnt + CNT_ONE;
         end

         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  state_r    <= ST_WAIT_SOF;
                  num_r      <= num_eff_s;
                  in_frame_r <= CNT_ZERO;
                  busy       <= 1'b1;
               end
            end
            ST_WAIT_SOF: begin
               if (take_s) begin
                  state_r <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (s2_valid_r && s2_last_r && s2_end_r) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_power_spec_accumulator.sv
// Randomized self-checking bench: frames are built in arrays, summed by a simple
// per-bin model, and the expected final spectrum is compared bin by bin.
module tb_power_spec_accumulator;

   localparam int NFFT  = 1024;
   localparam int IN_W  = 32;
   localparam int CNT_W = 16;
   localparam int ACC_W = 48;
   localparam int IDX_W = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             acc_start;
   logic [CNT_W-1:0] acc_num;
   logic [IN_W-1:0]  power_spec;
   logic [IDX_W-1:0] data_index;
   logic             data_valid;
   logic [ACC_W-1:0] acc_data;
   logic [IDX_W-1:0] acc_index;
   logic             acc_valid;
   logic             acc_done;
   logic             busy;
   logic [CNT_W-1:0] frame_cnt;

   power_spec_accumulator #(
      .NFFT(NFFT), .IN_W(IN_W), .CNT_W(CNT_W), .ACC_W(ACC_W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .acc_start(acc_start), .acc_num(acc_num),
      .power_spec(power_spec), .data_index(data_index), .data_valid(data_valid),
      .acc_data(acc_data), .acc_index(acc_index), .acc_valid(acc_valid),
      .acc_done(acc_done), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [63:0] val;
   } exp_t;

   int               n_checks = 0;
   int               n_pass = 0;
   logic [IN_W-1:0]  frm [NFFT];
   logic [63:0]      exp_sum [NFFT];
   exp_t             exp_q [$];
   exp_t             mon_e;
   int               in_edge [NFFT];
   int               cyc = 0;
   int               n_valid = 0;
   bit               restart_armed = 1'b0;
   logic [CNT_W-1:0] restart_num = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every acc_valid beat must match the next expected bin
   always @(negedge clk) begin
      if (acc_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 64'(acc_valid), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            chk("acc_index", 64'(acc_index), 64'(mon_e.idx));
            chk("acc_data", 64'(acc_data), mon_e.val);
            chk("acc_done", 64'(acc_done), 64'(mon_e.idx == NFFT - 1));
            chk("latency", 64'(cyc - in_edge[acc_index]), 64'(2));
         end
      end else if (acc_done) begin
         chk("done_without_valid", 64'(acc_done), 64'(0));
      end
   end

   task automatic drive(input logic st, input logic [CNT_W-1:0] n, input logic v,
                        input int idx, input logic [IN_W-1:0] pw);
      @(negedge clk);
      if (restart_armed && acc_done) begin
         st = 1'b1;
         n = restart_num;
         restart_armed = 1'b0;
      end
      acc_start  = st;
      acc_num    = n;
      data_valid = v;
      data_index = idx[IDX_W-1:0];
      power_spec = pw;
      if (v) in_edge[idx] = cyc + 1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 0, '0);
   endtask

   // kind: 0 random, 1 index+1, 2 all ones, 3 repeat previous frame
   task automatic fill_frame(input int kind);
      for (int i = 0; i < NFFT; i++) begin
         case (kind)
            0:       frm[i] = $urandom();
            1:       frm[i] = IN_W'(i + 1);
            2:       frm[i] = {IN_W{1'b1}};
            default: frm[i] = frm[i];
         endcase
      end
   endtask

   task automatic exp_add(input bit first);
      for (int i = 0; i < NFFT; i++)
         exp_sum[i] = first ? 64'(frm[i]) : exp_sum[i] + 64'(frm[i]);
   endtask

   task automatic exp_push();
      for (int i = 0; i < NFFT; i++) exp_q.push_back('{i, exp_sum[i]});
   endtask

   // gap: 0 contiguous, 1 valid toggling, 2 random idle cycles
   task automatic send_frame(input int from, input int to, input int gap,
                             input int start_bin, input logic [CNT_W-1:0] start_num);
      for (int b = from; b <= to; b++) begin
         drive(b == start_bin, start_num, 1'b1, b, frm[b]);
         if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) idle();
      end
   endtask

   task automatic run(input int n_eff, input int kind, input int gap,
                      input int start_bin, input logic [CNT_W-1:0] start_num);
      for (int f = 0; f < n_eff; f++) begin
         fill_frame((kind == 3 && f == 0) ? 0 : kind);
         exp_add(f == 0);
         if (f == n_eff - 1) exp_push();
         send_frame(0, NFFT - 1, gap, (f == 0) ? start_bin : -1, start_num);
      end
   endtask

   task automatic arm(input logic [CNT_W-1:0] num);
      drive(1'b1, num, 1'b0, 0, '0);
      idle();
      chk("busy_rise", 64'(busy), 64'(1));
      chk("frame_cnt_clr", 64'(frame_cnt), 64'(0));
   endtask

   task automatic wait_done(input int exp_frames, input int exp_valid);
      bit seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         idle();
         if (acc_done) seen = 1'b1;
      end
      chk("done_seen", 64'(seen), 64'(1));
      chk("busy_fall", 64'(busy), 64'(0));
      chk("frame_cnt_end", 64'(frame_cnt), 64'(exp_frames));
      idle();
      chk("busy_after", 64'(busy), 64'(0));
      chk("done_one_cycle", 64'(acc_done), 64'(0));
      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      chk("valid_count", 64'(n_valid), 64'(exp_valid));
      n_valid = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_acc_data"}, 64'(acc_data), 64'(0));
      chk({tag, "_acc_index"}, 64'(acc_index), 64'(0));
      chk({tag, "_acc_valid"}, 64'(acc_valid), 64'(0));
      chk({tag, "_acc_done"}, 64'(acc_done), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
   endtask

   initial begin
      rst = 1'b1;
      acc_start = 1'b0; acc_num = '0; data_valid = 1'b0; data_index = '0; power_spec = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      idle();

      // Sum of 3 frames with power = index+1
      arm(16'd3);
      run(3, 1, 0, -1, '0);
      wait_done(3, NFFT);

      // Start pulsed mid-frame at bin 500, single shot
      fill_frame(0);
      send_frame(0, NFFT - 1, 0, 500, 16'd1);
      run(1, 0, 0, -1, '0);
      wait_done(1, NFFT);

      // Full-scale input with valid toggling, carries beyond 32 bits
      arm(16'd16);
      run(16, 2, 1, -1, '0);
      wait_done(16, NFFT);

      // Start while busy is ignored; then acc_num = 0 behaves as 1
      arm(16'd2);
      run(2, 0, 2, 300, 16'd5);
      wait_done(2, NFFT);
      arm(16'd0);
      run(1, 0, 0, -1, '0);
      wait_done(1, NFFT);

      // Reset during frame 2 of 4
      arm(16'd4);
      fill_frame(0);
      send_frame(0, NFFT - 1, 0, -1, '0);
      fill_frame(0);
      send_frame(0, 600, 0, -1, '0);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("midrun_reset");
      idle();
      idle();
      rst = 1'b0;
      fill_frame(0);
      send_frame(0, NFFT - 1, 0, -1, '0);
      idle();
      chk("post_reset_idle", 64'(busy), 64'(0));
      arm(16'd2);
      run(2, 3, 0, -1, '0);
      wait_done(2, NFFT);

      // Back-to-back runs: restart on the cycle after acc_done, frames contiguous
      arm(16'd2);
      run(2, 0, 0, -1, '0);
      restart_num = 16'd2;
      restart_armed = 1'b1;
      fill_frame(0);
      send_frame(0, NFFT - 1, 0, -1, '0);
      chk("restart_fired", 64'(restart_armed), 64'(0));
      chk("restart_busy", 64'(busy), 64'(1));
      run(2, 0, 0, -1, '0);
      wait_done(2, 2 * NFFT);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/power_spec_accumulator.md
# power_spec_accumulator

Accumulates successive 1024-bin power spectra from the FFT power-spectrum stage, bin by bin, over a programmable number of laser shots. It uses an internal dual-port block RAM. On the final shot it streams the accumulated spectrum downstream to the averaging/upload logic. It sits directly after the power-spectrum calculator and consumes its `Power_Spec` / `data_index` / `data_valid` stream unchanged.

## Interface
- `NFFT`, 1024: bins per spectrum; index width is log2(NFFT).
- `IN_W`, 32: input power word width.
- `CNT_W`, 16: shot-count width.
- `ACC_W`, 48: accumulator width; must be at least IN_W+CNT_W.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `acc_start`  in  1  one-cycle pulse; arms an accumulation run.
- `acc_num`  in  CNT_W  number of spectra to sum; latched on an accepted `acc_start`.
- `power_spec`  in  IN_W  bin power (unsigned).
- `data_index`  in  10  bin index, 0..NFFT-1, ascending within a frame.
- `data_valid`  in  1  qualifies `power_spec` / `data_index`.
- `acc_data`  out  ACC_W  accumulated bin sum; valid only on the final shot.
- `acc_index`  out  10  bin index of `acc_data`.
- `acc_valid`  out  1  qualifies `acc_data` / `acc_index`.
- `acc_done`  out  1  one-cycle pulse with the last output bin.
- `busy`  out  1  high from an accepted start until `acc_done`.
- `frame_cnt`  out  CNT_W  number of frames completed in the current run.

## Operation
- State machine:
  - IDLE -> WAIT_SOF on `acc_start`. Latches `acc_num`; a value of 0 is treated as 1. Clears `frame_cnt`. Sets `busy`.
  - WAIT_SOF -> ACC on the first `data_valid` with `data_index`=0. Samples before that are discarded, so a start issued mid-frame aligns to the next frame.
  - ACC -> IDLE after the pipeline retires bin NFFT-1 of frame `acc_num`-1.
- `acc_start` is ignored outside IDLE. `data_valid` is ignored in IDLE.
- Read-modify-write per accepted sample:
  - RAM read address = `data_index`.
  - Sum = RAM word + zero-extended `power_spec`.
  - Result is written back to the same address.
- First frame of a run (`frame_cnt`=0): the RAM read is ignored and the zero-extended `power_spec` is written. No RAM clear is needed, and stale contents after reset are harmless.
- Last frame (`frame_cnt`=`acc_num`-1): the sum drives `acc_data` with `acc_valid`=1. Write-back still occurs.
- Frame end is bin NFFT-1 accepted in ACC. `frame_cnt` increments when that bin leaves the pipeline.
- Gaps in `data_valid` inside a frame are allowed; bins simply stall.
- Upstream guarantees complete, ascending frames. Behaviour on out-of-order indices is undefined except that the block never hangs: return to IDLE still requires bin NFFT-1.
- Arithmetic is unsigned. No overflow is possible with the chosen widths, so no saturation is applied.

## Timing
- Reset values: `acc_data`=0, `acc_index`=0, `acc_valid`=0, `acc_done`=0, `busy`=0, `frame_cnt`=0, state IDLE.
- Reset mid-run aborts immediately. No further outputs appear until a new `acc_start`.
- `busy` rises on the edge after `acc_start` is sampled in IDLE.
- Pipeline, for a sample accepted at edge k:
  - k: input registered; RAM read issued.
  - k+1: RAM data available.
  - k+2: sum registered. `acc_*` outputs update here (latency 2).
  - k+3: RAM write.
- No read-after-write hazard exists: the same bin is never revisited within 3 cycles, because frames are NFFT cycles or longer.
- Back-to-back frames with zero idle cycles are supported.
- `acc_done` is coincident with `acc_valid` for `acc_index`=NFFT-1 of the last frame.
- `busy` falls on the same edge that `acc_done` asserts.
- A new `acc_start` is accepted on the cycle after `acc_done`.
- Throughput: 1 bin/clock sustained.

## Test plan
- **Sum of 3 frames.** Set `acc_num`=3, feed 3 contiguous frames with `power_spec`=`data_index`+1. Required: exactly 1024 `acc_valid` cycles with `acc_data`=3·(i+1) at `acc_index` i; `acc_done` once at i=1023; `busy` low the following cycle; `frame_cnt` reaches 3.
- **Mid-frame start.** Pulse `acc_start` while upstream is at bin 500. Required: bins 500..1023 are ignored; the sum starts at the next bin 0. With `acc_num`=1, `acc_data` equals the input delayed 2 cycles.
- **Gappy input and width check.** Set `acc_num`=65535, `power_spec`=32'hFFFFFFFF, `data_valid` toggling 1/0. Required: final `acc_data`=48'hFFFE_FFFF_0001 at every bin, with no loss and no overflow.
- **Start while busy and `acc_num`=0.** Pulse `acc_start` again mid-run with a different `acc_num`. Required: the pulse is ignored and the original count completes. Then run with `acc_num`=0. Required: it behaves as 1.
- **Reset mid-run.** Assert `rst` during frame 2 of 4. Required: all outputs return to reset values at once. A following run with `acc_num`=2 gives 2·input exactly, unaffected by stale RAM.
- **Back-to-back runs.** Issue `acc_start` on the cycle after `acc_done`, with frames contiguous. Required: the second run aligns to the next bin 0 and produces correct sums.
